muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. Consumes the forwarded ALU operands (post-forwarding-mux `alu_input_a_e` / `alu_input_b_e`) when the decoded instruction is an M-extension op. Holds the pipeline through a stall request to the hazard unit until the result is ready, then presents a 32-bit result for the execute-stage result select.

## Interface

Parameters:
- `XLEN`, default 32: operand/result width; only 32 is supported.

Ports:
- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start_e`  input  1  the instruction in E is an M-extension op. Held high by the pipeline for as long as `stall_md_e` holds it.
- `op_e`  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a_e`  input  32  rs1 value (forwarded).
- `operand_b_e`  input  32  rs2 value (forwarded).
- `flush_e`  input  1  E-stage flush from the hazard unit; aborts any operation in progress.
- `stall_md_e`  output  1  stall request to the hazard unit (F/D/E held).
- `done_md_e`  output  1  one-cycle pulse: `result_md_e` is valid this cycle.
- `result_md_e`  output  32  registered result.

## Operation

- States: IDLE, BUSY, DONE (enum in the package).
- **IDLE**
  - If `start_e && !flush_e`: latch op, operand magnitudes, sign flags and result-negate flag; load the iteration counter with 31.
  - A div op with `b==0` or signed overflow (`a==0x80000000`, `b==0xFFFFFFFF`, DIV/REM) goes straight to DONE.
  - Every other op goes to BUSY.
- **BUSY**
  - Division: one restoring shift-subtract step per cycle on unsigned magnitudes.
  - Multiplication: one shift-add step per cycle on 33-bit magnitudes into a 64-bit accumulator.
  - Counter decrements each cycle; at 0, apply sign fix and go to DONE.
- **DONE**
  - `done_md_e`=1 and the result is held.
  - Go to IDLE unconditionally next cycle. `start_e` is still high in DONE for the same instruction and must not relaunch.
- **Stall rule:** `stall_md_e = (state==IDLE && start_e && !flush_e) || state==BUSY`. It is deasserted in DONE so the instruction advances with the result.
- **Flush:** `flush_e` in any state sends the unit to IDLE next cycle. No `done_md_e` pulse; the result register is unchanged.
- **Special results:**
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend (a).
  - Overflow: quotient 0x80000000, remainder 0.
- **Signedness:**
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- **Result select:**
  - MUL: low 32 bits of the product; MULH*: high 32 bits.
  - DIV*: quotient; REM*: remainder.
- **Reset:** state IDLE, counter 0, `result_md_e`=0, `done_md_e`=0, `stall_md_e`=0 when `start_e`=0. Reset overrides start and flush, including mid-operation.

## Timing

- Start is accepted at edge 0 (IDLE with `start_e` high).
- Iterative ops: BUSY for 32 cycles. DONE is in the 33rd cycle after acceptance (`stall_md_e` high for 33 cycles total including the accept cycle). Total E occupancy is 34 cycles.
- Special-case div: DONE in the cycle after acceptance (stall high for 1 cycle).
- Back-to-back M ops: the second one sees IDLE in the cycle after DONE. There are no dead cycles beyond that.
- `result_md_e` and `done_md_e` are registered. `stall_md_e` is combinational from state, `start_e` and `flush_e`.

## Configuration

- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed product.
  - Accept goes to DONE directly (1-cycle stall, as for div special cases).
  - The BUSY path is used by division only.
- `MULDIV_FAST_MUL_EN` undefined: multiplication uses the 32-cycle shift-add path.
- Division behaviour is identical either way.

## Structure

- `muldiv_pkg` contains:
  - `muldiv_op_t` (funct3 encodings);
  - `muldiv_state_t` (IDLE/BUSY/DONE);
  - `MULDIV_ITERS` = 32;
  - `DIV_ZERO_Q` = 32'hFFFFFFFF;
  - `INT_MIN` = 32'h80000000.
- One sub-module: `muldiv_iter_step`. It is the combinational single-step datapath: one shift-subtract or shift-add given accumulator, operand and op class. It is instantiated once and driven by the FSM/counter in `muldiv_unit`.

## Test plan

- DIVU a=100, b=7 -> stall 33 cycles, `done_md_e` pulse, result 14. REMU of the same operands -> 2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1).
- DIV a=5, b=0 -> 0xFFFFFFFF after 1 stall cycle. REM a=5, b=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, 1 stall cycle.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MUL -> 0. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. Latency is 33 or 1 stall cycles depending on `MULDIV_FAST_MUL_EN`.
- DIVU 100/7 with `flush_e` pulsed 10 cycles after accept -> `stall_md_e` low the next cycle, no `done_md_e`, state IDLE, next DIVU 9/3 -> 3.
- `rst` asserted mid-BUSY -> next cycle all outputs 0, state IDLE. `start_e` held high through DONE -> exactly one `done_md_e` pulse, no relaunch.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    localparam int          MULDIV_ITERS = 32;
    localparam logic [31:0] DIV_ZERO_Q   = 32'hFFFFFFFF;
    localparam logic [31:0] INT_MIN      = 32'h80000000;

    function automatic logic op_signed_a(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: restoring shift-subtract (divide) or shift-add (multiply).
module muldiv_iter_step
(
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] partial;
    logic [32:0] diff;

    always_comb begin
        partial  = '0;
        diff     = '0;
        acc_next = acc;
        if (is_div) begin
            // acc = {remainder, dividend bits still to shift in}; bit 32 of diff is the borrow
            partial = acc[63:31];
            diff    = partial - {1'b0, operand};
            if (!diff[32]) begin
                acc_next = {diff[31:0], acc[30:0], 1'b1};
            end else begin
                acc_next = {partial[31:0], acc[30:0], 1'b0};
            end
        end else begin
            partial  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
            acc_next = {partial, acc[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Optional single-cycle multiply when MULDIV_FAST_MUL_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_e,
    input  logic [2:0]      op_e,
    input  logic [XLEN-1:0] operand_a_e,
    input  logic [XLEN-1:0] operand_b_e,
    input  logic            flush_e,
    output logic            stall_md_e,
    output logic            done_md_e,
    output logic [XLEN-1:0] result_md_e
);

    muldiv_state_t state;
    muldiv_op_t    op_q;
    logic [4:0]    cnt;
    logic [63:0]   acc;
    logic [63:0]   acc_nxt;
    logic [31:0]   opnd;
    logic          neg_q;
    logic          neg_r;

    muldiv_op_t    op_in;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic          div_zero;
    logic          div_ovf;

    function automatic logic [31:0] finish_result(input muldiv_op_t op, input logic [63:0] raw,
                                                  input logic nq, input logic nr);
        logic [63:0] prod;
        logic [31:0] quo;
        logic [31:0] rem;
        prod = nq ? -raw : raw;
        quo  = nq ? -raw[31:0] : raw[31:0];
        rem  = nr ? -raw[63:32] : raw[63:32];
        case (op)
            OP_MUL:                       return prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return prod[63:32];
            OP_DIV, OP_DIVU:              return quo;
            default:                      return rem;
        endcase
    endfunction

`ifdef MULDIV_FAST_MUL_EN
    function automatic logic [31:0] fast_mul(input muldiv_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [32:0] sa;
        logic signed [32:0] sb;
        logic signed [63:0] p;
        sa = {op_signed_a(op) & a[31], a};
        sb = {op_signed_b(op) & b[31], b};
        p  = 64'(sa) * 64'(sb);
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction
`endif

    always_comb begin
        op_in    = muldiv_op_t'(op_e);
        a_neg    = op_signed_a(op_in) & operand_a_e[31];
        b_neg    = op_signed_b(op_in) & operand_b_e[31];
        a_mag    = a_neg ? -operand_a_e : operand_a_e;
        b_mag    = b_neg ? -operand_b_e : operand_b_e;
        div_zero = (operand_b_e == '0);
        div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                   operand_a_e == INT_MIN && operand_b_e == '1;
    end

    muldiv_iter_step u_step (
        .is_div   (op_q[2]),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_nxt)
    );

    assign stall_md_e = (state == ST_IDLE && start_e && !flush_e) || state == ST_BUSY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            result_md_e <= '0;
            done_md_e   <= 1'b0;
        end else begin
            done_md_e <= 1'b0;
            if (flush_e) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_e) begin
                            op_q  <= op_in;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            cnt   <= 5'(MULDIV_ITERS - 1);
                            if (op_e[2]) begin
                                acc  <= {32'd0, a_mag};
                                opnd <= b_mag;
                                if (div_zero) begin
                                    result_md_e <= op_e[1] ? operand_a_e : DIV_ZERO_Q;
                                    done_md_e   <= 1'b1;
                                    state       <= ST_DONE;
                                end else if (div_ovf) begin
                                    result_md_e <= op_e[1] ? 32'd0 : INT_MIN;
                                    done_md_e   <= 1'b1;
                                    state       <= ST_DONE;
                                end else begin
                                    state <= ST_BUSY;
                                end
                            end else begin
`ifdef MULDIV_FAST_MUL_EN
                                result_md_e <= fast_mul(op_in, operand_a_e, operand_b_e);
                                done_md_e   <= 1'b1;
                                state       <= ST_DONE;
`else
                                acc   <= {32'd0, b_mag};
                                opnd  <= a_mag;
                                state <= ST_BUSY;
`endif
                            end
                        end
                    end
                    ST_BUSY: begin
                        acc <= acc_nxt;
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) begin
                            result_md_e <= finish_result(op_q, acc_nxt, neg_q, neg_r);
                            done_md_e   <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_e = 1'b0;
    logic [2:0]  op_e = 3'd0;
    logic [31:0] operand_a_e = '0;
    logic [31:0] operand_b_e = '0;
    logic        flush_e = 1'b0;
    logic        stall_md_e;
    logic        done_md_e;
    logic [31:0] result_md_e;

    int passes = 0;
    int total  = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_e     (start_e),
        .op_e        (op_e),
        .operand_a_e (operand_a_e),
        .operand_b_e (operand_b_e),
        .flush_e     (flush_e),
        .stall_md_e  (stall_md_e),
        .done_md_e   (done_md_e),
        .result_md_e (result_md_e)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'b000: begin p = 64'(ua * ub); return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = 64'(ua * ub); return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(sa / sb);
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : 32'(ua / ub);
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic int ref_stalls(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'b100 || op == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    // Issues one op, holds start through DONE, then drops it as the instruction leaves E.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int stalls = 0;
        @(posedge clk); #1;
        start_e = 1'b1; op_e = op; operand_a_e = a; operand_b_e = b;
        for (int guard = 0; guard < 100; guard++) begin
            @(negedge clk);
            if (!stall_md_e) break;
            stalls++;
            @(posedge clk); #1;
        end
        check({tag, ".stall_cycles"}, 32'(stalls), 32'(ref_stalls(op, a, b)));
        check({tag, ".done"}, {31'd0, done_md_e}, 32'd1);
        check({tag, ".result"}, result_md_e, ref_result(op, a, b));
        @(posedge clk); #1;
        start_e = 1'b0;
        @(negedge clk);
        check({tag, ".single_pulse"}, {31'd0, done_md_e}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        seen_done;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.stall", {31'd0, stall_md_e}, 32'd0);
        check("reset.done", {31'd0, done_md_e}, 32'd0);
        check("reset.result", result_md_e, 32'd0);
        check("reset.state", 32'(dut.state), 32'(ST_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;

        do_op("divu", 3'b101, 32'd100, 32'd7);
        do_op("remu", 3'b111, 32'd100, 32'd7);
        do_op("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2);
        do_op("rem_neg", 3'b110, 32'hFFFFFFF9, 32'd2);
        do_op("div_zero", 3'b100, 32'd5, 32'd0);
        do_op("rem_zero", 3'b110, 32'd5, 32'd0);
        do_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF);
        do_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF);
        do_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000);
        do_op("mul_min", 3'b000, 32'h80000000, 32'h80000000);
        do_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_op("mulhsu_neg", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // Flush ten cycles into a divide
        @(posedge clk); #1;
        start_e = 1'b1; op_e = 3'b101; operand_a_e = 32'd100; operand_b_e = 32'd7;
        repeat (10) begin
            @(posedge clk); #1;
        end
        flush_e = 1'b1; start_e = 1'b0;
        @(negedge clk);
        check("flush.done_in_flush", {31'd0, done_md_e}, 32'd0);
        @(posedge clk); #1;
        flush_e = 1'b0;
        @(negedge clk);
        check("flush.stall_after", {31'd0, stall_md_e}, 32'd0);
        check("flush.state", 32'(dut.state), 32'(ST_IDLE));
        seen_done = done_md_e;
        repeat (40) begin
            @(negedge clk);
            seen_done = seen_done | done_md_e;
        end
        check("flush.no_done", {31'd0, seen_done}, 32'd0);
        do_op("after_flush", 3'b101, 32'd9, 32'd3);

        // Reset in the middle of a divide
        @(posedge clk); #1;
        start_e = 1'b1; op_e = 3'b100; operand_a_e = 32'd1000; operand_b_e = 32'd3;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; start_e = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst.stall", {31'd0, stall_md_e}, 32'd0);
        check("midrst.done", {31'd0, done_md_e}, 32'd0);
        check("midrst.result", result_md_e, 32'd0);
        check("midrst.state", 32'(dut.state), 32'(ST_IDLE));

        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 1) rb = 32'($urandom_range(1, 300));
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
